// File: rtl/ifu_prefetch_if.sv
// Signal bundle between the fetch stage, the instruction memory port and the execute unit.
// The master modport is the fetch stage's view; the slave modport is the environment's view.
interface ifu_prefetch_if;
    logic        req;
    logic        ack;
    logic [15:0] dtr;
    logic [19:0] adr;
    logic        sigflush;
    logic [20:0] fladr;
    logic        ivalid;
    logic        iready;
    logic [31:0] instr;
    logic [19:0] ipc;

    modport master (
        output req, adr, ivalid, instr, ipc,
        input  ack, dtr, sigflush, fladr, iready
    );

    modport slave (
        input  req, adr, ivalid, instr, ipc,
        output ack, dtr, sigflush, fladr, iready
    );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction fetch/prefetch stage: fetches 16-bit words into a small queue and presents 32-bit instructions.
// Define IFU_DROP_CNT_EN to add the saturating drop_cnt output counting words discarded by flushes.
module ifu_prefetch #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [19:0] RESET_VEC = 20'h00000
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef IFU_DROP_CNT_EN
    output logic [15:0]       drop_cnt,
`endif
    ifu_prefetch_if.master    bus
);
    localparam int unsigned   AW   = $clog2(DEPTH);
    localparam int unsigned   CW   = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        state_q;
    logic          req_q;
    logic [19:0]   adr_q;
    logic [19:0]   fptr_q;
    logic [19:0]   ipc_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [15:0]   mem_q [DEPTH];

    logic          flush;
    logic          push;
    logic          pop;
    logic          ivalid;
    logic [19:0]   flush_wadr;
    logic [AW-1:0] rd_ptr_p1;
    logic [CW-1:0] count_d;
    logic          unused_fladr_lsb;

    assign flush            = bus.sigflush;
    assign flush_wadr       = bus.fladr[20:1];
    assign unused_fladr_lsb = bus.fladr[0];
    assign ivalid           = (count_q >= CW'(2));
    assign push             = (state_q == REQ) && bus.ack && !flush;
    assign pop              = ivalid && bus.iready && !flush;
    assign rd_ptr_p1        = rd_ptr_q + AW'(1);
    // Occupancy after this cycle's push and pop, ignoring a flush.
    assign count_d          = count_q + CW'(push) - (pop ? CW'(2) : CW'(0));

    generate
        for (genvar gi = 0; gi < int'(DEPTH); gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == AW'(gi))) begin
                    mem_q[gi] <= bus.dtr;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ipc_q    <= RESET_VEC;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ipc_q    <= flush_wadr;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(2);
                ipc_q    <= ipc_q + 20'd2;
            end
            count_q <= count_d;
        end
    end

    // adr_q equals fptr_q while in REQ; in DROP it keeps the stale address until its ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            adr_q   <= RESET_VEC;
            fptr_q  <= RESET_VEC;
        end else if (flush) begin
            fptr_q <= flush_wadr;
            case (state_q)
                REQ: begin
                    if (bus.ack) begin
                        adr_q <= flush_wadr;
                    end else begin
                        state_q <= DROP;
                    end
                end
                DROP: begin
                    if (bus.ack) begin
                        state_q <= REQ;
                        adr_q   <= flush_wadr;
                    end
                end
                default: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                    adr_q   <= flush_wadr;
                end
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q < FULL) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        adr_q   <= fptr_q;
                    end
                end
                REQ: begin
                    if (bus.ack) begin
                        fptr_q <= fptr_q + 20'd1;
                        adr_q  <= fptr_q + 20'd1;
                        if (count_d >= FULL) begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (bus.ack) begin
                        state_q <= REQ;
                        adr_q   <= fptr_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFU_DROP_CNT_EN
    logic [15:0] drop_cnt_q;
    logic        inflight_drop;
    logic [16:0] drop_sum;

    assign inflight_drop = bus.ack && ((state_q == DROP) || ((state_q == REQ) && flush));
    assign drop_sum      = {1'b0, drop_cnt_q} + 17'(flush ? count_q : CW'(0)) + 17'(inflight_drop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign bus.req    = req_q;
    assign bus.adr    = adr_q;
    assign bus.ivalid = ivalid;
    assign bus.instr  = {mem_q[rd_ptr_q], mem_q[rd_ptr_p1]};
    assign bus.ipc    = ipc_q;
endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
Instruction fetch and prefetch stage directly upstream of the execute unit.
- Fetches 16-bit words over the word-wide memory handshake into a small queue.
- Presents 32-bit instructions with a valid/ready handshake.
- On a flush from the execute unit, discards queued and in-flight words and restarts fetch at the flush address.

Parameters:
DEPTH, 4, queue depth in 16-bit words; power of two, >= 2.
RESET_VEC, 20'h00000, word address fetched first after reset.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst_n  in  1  reset; synchronous, active-low.
req  out  1  memory request, active-high; held until ack.
ack  in  1  one-cycle pulse; dtr is valid in the same cycle.
dtr  in  16  read data from memory.
adr  out  20  word address of current request; stable while req=1.
sigflush  in  1  one-cycle flush/redirect strobe from the execute unit.
fladr  in  21  byte address of flush target; word address = fladr[20:1]; fladr[0] ignored.
ivalid  out  1  instruction available.
iready  in  1  execute unit accepts the instruction.
instr  out  32  {head word, head+1 word}; first-fetched word in [31:16].
ipc  out  20  word address of instr[31:16].

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - req=0, adr=RESET_VEC, ivalid=0, queue count=0, ipc=RESET_VEC, state=IDLE.
  - Reset overrides any outstanding request; a later stray ack is not expected.
- Queue:
  - Circular buffer of DEPTH words; rd/wr pointers wrap modulo DEPTH.
  - count is 0..DEPTH.
- FSM states:
  - IDLE: if count < DEPTH, assert req with adr = fetch pointer; go to REQ. Otherwise stay.
  - REQ: hold req and adr. On ack:
    - push dtr, increment fetch pointer by 1 (mod 2^20);
    - if count+1 (after any same-cycle pop) < DEPTH, stay in REQ with next adr (back-to-back);
    - else req=0 and go to IDLE.
  - DROP: flushed while a request is outstanding. req and old adr are held. On ack, discard dtr, set adr to the flush address, and go to REQ with req=1.
  - Only one request outstanding at a time.
- Output:
  - ivalid = (count >= 2), derived from registered state; instr and ipc come from the head.
  - Pop of 2 words occurs when ivalid && iready; ipc += 2 (mod 2^20).
  - A push and a pop in the same cycle are both performed, so count changes by +1-2.
  - instr/ipc are stable while ivalid=1 && iready=0.
- Flush (sigflush=1) takes priority over push and pop in that cycle:
  - Queue cleared (count=0), ipc = fetch pointer = fladr[20:1].
  - ivalid=0 from the next cycle until 2 new words arrive.
  - If state=REQ and ack=0: go to DROP.
  - If state=REQ and ack=1: the word is discarded; go to REQ at the new address next cycle.
  - If state=IDLE: go to REQ at the new address.
  - A flush while in DROP updates the pending target; still wait for ack.
- Fetch pointer wraps 20'hFFFFF -> 20'h00000 with no fault.
- Latency:
  - ack in cycle k -> word visible in the queue at k+1.
  - Minimum flush-to-ivalid is 2 acks + 1 cycle.

Optional Feature:
IFU_DROP_CNT_EN
- Defined: adds output drop_cnt [15:0]. It counts words discarded by flush: queued words cleared, plus the in-flight word dropped via DROP or via a same-cycle ack.
  - Saturates at 16'hFFFF.
  - Reset value is 0.
- Not defined: no port and no counter logic; all other behaviour is identical.

Test Plan:
1. Reset, then release with ack returning 1 cycle after each req, iready=0, DEPTH=4 -> adr 0,1,2,3 issued; req drops after the 4th ack; ivalid=1 with instr={w0,w1}, ipc=0; no further req.
2. Continuous iready=1, memory returning dtr=adr+16'h100 -> instr sequence 0x01000101, 0x01020103, ...; ipc 0,2,4; back-to-back req with no gaps and no count overflow.
3. sigflush with fladr=21'h00210 while req is outstanding with no ack, ack arriving 3 cycles later -> that data is dropped, ivalid stays 0, next adr=20'h00108, ipc=20'h00108 at first valid.
4. sigflush in the same cycle as ack and as an ivalid&&iready pop -> no pop, no push, count=0, next adr=fladr[20:1] (drop_cnt += queued words + 1 if enabled).
5. Fetch pointer at 20'hFFFFF -> next adr=20'h00000; instr spans the wrap correctly with ipc=20'hFFFFF.
6. Assert rst_n=0 mid-REQ for 1 cycle -> req=0, ivalid=0, adr=RESET_VEC next cycle; fetch restarts from RESET_VEC.
